// File: rtl/spi_lcd_stream_ctrl.sv
// SPI LCD controller: panel reset/init sequencing, address-window setup,
// and RGB565 pixel streaming over a 4-wire SPI (cs/clk/mosi/rs).
module spi_lcd_stream_ctrl #(
  parameter int        H_RES     = 240,
  parameter int        V_RES     = 135,
  parameter int        X_OFS     = 40,
  parameter int        Y_OFS     = 53,
  parameter logic [7:0] MADCTL   = 8'h70,
  parameter int        CLK_DIV   = 1,
  parameter int        T_RESET   = 2700000,
  parameter int        T_PREPARE = 5400000,
  parameter int        T_SNOOZE  = 3240000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        init_done,
  input  logic        bl_en,
  output logic        lcd_resetn,
  output logic        lcd_clk,
  output logic        lcd_cs,
  output logic        lcd_rs,
  output logic        lcd_data,
  output logic        lcd_bl
);

  typedef enum logic [2:0] {S_RESET, S_PREPARE, S_WAKEUP, S_SNOOZE,
                            S_INIT, S_WINDOW, S_STREAM} state_t;

  localparam int              CW     = $clog2(2*CLK_DIV);
  localparam logic [CW-1:0]   C_LAST = CW'(2*CLK_DIV-1);
  localparam logic [CW-1:0]   C_HALF = CW'(CLK_DIV-1);
  localparam int              PW     = $clog2(H_RES*V_RES+1);
  localparam logic [PW-1:0]   NPIX   = PW'(H_RES*V_RES);
  localparam logic [31:0]     D_RST  = 32'(T_RESET-1);
  localparam logic [31:0]     D_PREP = 32'(T_PREPARE-1);
  localparam logic [31:0]     D_SNZ  = 32'(T_SNOOZE-1);
  localparam logic [15:0]     XS     = 16'(X_OFS);
  localparam logic [15:0]     XE     = 16'(X_OFS+H_RES-1);
  localparam logic [15:0]     YS     = 16'(Y_OFS);
  localparam logic [15:0]     YE     = 16'(Y_OFS+V_RES-1);

  state_t          r_state, w_next;
  logic [31:0]     r_dly;
  logic [3:0]      r_idx;
  logic [PW-1:0]   r_pixcnt;
  logic [7:0]      r_pix_lo;
  logic            r_init_done, r_frame_start;

  // byte shifter state
  logic            r_busy, r_clk, r_cs, r_dat, r_rs;
  logic [7:0]      r_sh;
  logic [3:0]      r_bit;
  logic [CW-1:0]   r_cnt;

  logic            w_done, w_free, w_start, w_have, w_rs, w_accept;
  logic [7:0]      w_byte;

  // done is the last cycle of the inter-byte gap; a new byte may load then
  assign w_done   = r_busy && (r_bit == 4'd8) && (r_cnt == C_LAST);
  assign w_free   = !r_busy || w_done;
  assign w_start  = w_free && w_have;
  assign w_accept = (r_state == S_STREAM) && (r_idx == 4'd0) && w_start;

  assign lcd_resetn  = (r_state != S_RESET);
  assign lcd_clk     = r_clk;
  assign lcd_cs      = r_cs;
  assign lcd_rs      = r_rs;
  assign lcd_data    = r_dat;
  assign lcd_bl      = bl_en;
  assign init_done   = r_init_done;
  assign frame_start = r_frame_start;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_RESET;
    else         r_state <= w_next;
  end

  // next-state: delay states time out, byte states finish when the engine drains
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:   if (r_dly == D_RST)  w_next = S_PREPARE;
      S_PREPARE: if (r_dly == D_PREP) w_next = S_WAKEUP;
      S_WAKEUP:  if (!r_busy && r_idx == 4'd1)  w_next = S_SNOOZE;
      S_SNOOZE:  if (r_dly == D_SNZ)  w_next = S_INIT;
      S_INIT:    if (!r_busy && r_idx == 4'd6)  w_next = S_WINDOW;
      S_WINDOW:  if (!r_busy && r_idx == 4'd11) w_next = S_STREAM;
      S_STREAM:  if (!r_busy && r_idx == 4'd2 && r_pixcnt == NPIX) w_next = S_WINDOW;
      default:   w_next = S_RESET;
    endcase
  end

  // outputs: byte to send next (rs + value) and stream handshake
  always_comb begin
    w_have    = 1'b0;
    w_byte    = 8'h00;
    w_rs      = 1'b0;
    pix_ready = 1'b0;
    case (r_state)
      S_WAKEUP: begin
        w_have = (r_idx == 4'd0);
        w_byte = 8'h11;
      end
      S_INIT: begin
        w_have = (r_idx < 4'd6);
        case (r_idx)
          4'd0:    w_byte = 8'h36;
          4'd1:    begin w_byte = MADCTL; w_rs = 1'b1; end
          4'd2:    w_byte = 8'h3A;
          4'd3:    begin w_byte = 8'h05;  w_rs = 1'b1; end
          4'd4:    w_byte = 8'h21;
          default: w_byte = 8'h29;
        endcase
      end
      S_WINDOW: begin
        w_have = (r_idx < 4'd11);
        w_rs   = 1'b1;
        case (r_idx)
          4'd0:    begin w_byte = 8'h2A; w_rs = 1'b0; end
          4'd1:    w_byte = XS[15:8];
          4'd2:    w_byte = XS[7:0];
          4'd3:    w_byte = XE[15:8];
          4'd4:    w_byte = XE[7:0];
          4'd5:    begin w_byte = 8'h2B; w_rs = 1'b0; end
          4'd6:    w_byte = YS[15:8];
          4'd7:    w_byte = YS[7:0];
          4'd8:    w_byte = YE[15:8];
          4'd9:    w_byte = YE[7:0];
          default: begin w_byte = 8'h2C; w_rs = 1'b0; end
        endcase
      end
      S_STREAM: begin
        w_rs      = 1'b1;
        pix_ready = !r_busy && (r_idx == 4'd0);
        if (r_idx == 4'd0) begin
          w_have = pix_valid && !r_busy;
          w_byte = pix_data[15:8];
        end else if (r_idx == 4'd1) begin
          w_have = 1'b1;
          w_byte = r_pix_lo;
        end
      end
      default: ;
    endcase
  end

  // sequencing: delay timer, byte index, pixel counter, status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dly         <= '0;
      r_idx         <= '0;
      r_pixcnt      <= '0;
      r_pix_lo      <= '0;
      r_init_done   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_dly         <= (w_next != r_state) ? '0 : r_dly + 32'd1;
      r_frame_start <= (r_state != S_WINDOW) && (w_next == S_WINDOW);
      if (r_state == S_INIT && w_next == S_WINDOW) r_init_done <= 1'b1;
      if (w_next != r_state)                                        r_idx <= '0;
      else if (w_start)                                             r_idx <= r_idx + 4'd1;
      else if (r_state == S_STREAM && !r_busy && r_idx == 4'd2)     r_idx <= '0;
      if (w_next != r_state) r_pixcnt <= '0;
      else if (w_accept)     r_pixcnt <= r_pixcnt + 1'b1;
      if (w_accept) r_pix_lo <= pix_data[7:0];
    end
  end

  // SPI byte engine: 8 bit periods with cs low, then one idle bit period
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_clk  <= 1'b0;
      r_cs   <= 1'b1;
      r_dat  <= 1'b1;
      r_rs   <= 1'b1;
      r_sh   <= '0;
      r_bit  <= '0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_busy <= 1'b1;
      r_cs   <= 1'b0;
      r_clk  <= 1'b0;
      r_dat  <= w_byte[7];
      r_sh   <= w_byte;
      r_rs   <= w_rs;
      r_bit  <= '0;
      r_cnt  <= '0;
    end else if (w_done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == C_LAST) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        r_bit <= r_bit + 4'd1;
        if (r_bit == 4'd7) begin
          r_cs  <= 1'b1;
          r_dat <= 1'b1;
        end else if (r_bit < 4'd7) begin
          r_dat <= r_sh[6];
          r_sh  <= {r_sh[6:0], 1'b0};
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == C_HALF && r_bit < 4'd8) r_clk <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_stream_ctrl.sv
// Directed bench: boot, window, streaming with wrap, underrun, CLK_DIV=3
// timing and reset mid-pixel, against hand-computed byte streams.
module tb_spi_lcd_stream_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        bl_en;

  logic d1_ready, d1_fs, d1_idone, d1_rstn, d1_clk, d1_cs, d1_rs, d1_data, d1_bl;
  logic d3_ready, d3_fs, d3_idone, d3_rstn, d3_clk, d3_cs, d3_rs, d3_data, d3_bl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_lcd_stream_ctrl #(
    .H_RES(4), .V_RES(2), .X_OFS(40), .Y_OFS(53), .MADCTL(8'h70), .CLK_DIV(1),
    .T_RESET(4), .T_PREPARE(4), .T_SNOOZE(4)
  ) u_dut (
    .clk(clk), .resetn(resetn), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(d1_ready), .frame_start(d1_fs), .init_done(d1_idone), .bl_en(bl_en),
    .lcd_resetn(d1_rstn), .lcd_clk(d1_clk), .lcd_cs(d1_cs), .lcd_rs(d1_rs),
    .lcd_data(d1_data), .lcd_bl(d1_bl)
  );

  spi_lcd_stream_ctrl #(
    .H_RES(4), .V_RES(2), .X_OFS(40), .Y_OFS(53), .MADCTL(8'h70), .CLK_DIV(3),
    .T_RESET(4), .T_PREPARE(4), .T_SNOOZE(4)
  ) u_dut3 (
    .clk(clk), .resetn(resetn), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(d3_ready), .frame_start(d3_fs), .init_done(d3_idone), .bl_en(bl_en),
    .lcd_resetn(d3_rstn), .lcd_clk(d3_clk), .lcd_cs(d3_cs), .lcd_rs(d3_rs),
    .lcd_data(d3_data), .lcd_bl(d3_bl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // captured bytes {init_done, rs, byte}
  logic [9:0] q[$];
  logic [9:0] exp_q[$];
  logic [7:0] mon_sh;
  int         mon_bits;

  // shift in MOSI on each rising SPI clock; reset drops a partial byte
  always @(posedge d1_clk or negedge resetn) begin
    if (!resetn) mon_bits = 0;
    else if (!d1_cs) begin
      mon_sh = {mon_sh[6:0], d1_data};
      mon_bits++;
      if (mon_bits == 8) begin
        q.push_back({d1_idone, d1_rs, mon_sh});
        mon_bits = 0;
      end
    end
  end

  // frame_start pulse count and width
  int fs_cnt = 0, fs_wide = 0;
  logic fs_prev = 1'b0;
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (d1_fs) fs_cnt++;
      if (d1_fs && fs_prev) fs_wide++;
      fs_prev = d1_fs;
    end
  end

  task automatic push(input logic d, input logic r, input logic [7:0] b);
    exp_q.push_back({d, r, b});
  endtask

  task automatic push_window();
    push(1, 0, 8'h2A); push(1, 1, 8'h00); push(1, 1, 8'h28); push(1, 1, 8'h00); push(1, 1, 8'h2B);
    push(1, 0, 8'h2B); push(1, 1, 8'h00); push(1, 1, 8'h35); push(1, 1, 8'h00); push(1, 1, 8'h36);
    push(1, 0, 8'h2C);
  endtask

  // CLK_DIV=3 timing of the first byte on the second instance
  logic d3_finished = 1'b0;
  initial begin : clkdiv3
    int w, cs_low, hi, rises;
    logic prev;
    w = 0; cs_low = 0; hi = 0; rises = 0; prev = 1'b0;
    @(posedge resetn);
    while (d3_cs !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
    chk("d3_cs_seen", {31'd0, d3_cs}, 32'd0);
    while (d3_cs === 1'b0 && cs_low < 500) begin
      cs_low++;
      if (d3_clk) hi++;
      if (d3_clk && !prev) rises++;
      prev = d3_clk;
      @(negedge clk);
    end
    chk("d3_cs_low_cycles", cs_low, 48);
    chk("d3_clk_high_cycles", hi, 24);
    chk("d3_clk_rises", rises, 8);
    d3_finished = 1'b1;
  end

  logic [15:0] pix_tab [16];

  initial begin : main
    int n, k, cyc, bad;
    logic under_done;
    resetn = 1'b0; pix_valid = 1'b0; pix_data = 16'h0; bl_en = 1'b0;
    for (int i = 0; i < 8; i++) pix_tab[i] = 16'hF800;
    pix_tab[8]  = 16'h1234; pix_tab[9]  = 16'hABCD; pix_tab[10] = 16'h0001; pix_tab[11] = 16'h8000;
    pix_tab[12] = 16'hFFFF; pix_tab[13] = 16'h07E0; pix_tab[14] = 16'h001F; pix_tab[15] = 16'h5A5A;

    // expected byte stream: boot, window, 8 pixels, window, 8 pixels, window
    push(0, 0, 8'h11);
    push(0, 0, 8'h36); push(0, 1, 8'h70); push(0, 0, 8'h3A); push(0, 1, 8'h05);
    push(0, 0, 8'h21); push(0, 0, 8'h29);
    push_window();
    for (int i = 0; i < 8; i++) begin push(1, 1, pix_tab[i][15:8]); push(1, 1, pix_tab[i][7:0]); end
    push_window();
    for (int i = 8; i < 16; i++) begin push(1, 1, pix_tab[i][15:8]); push(1, 1, pix_tab[i][7:0]); end
    push_window();

    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, d1_rstn, d1_cs, d1_rs, d1_clk, d1_data, d1_ready, d1_fs, d1_idone},
        {24'd0, 8'b0110_1000});
    bl_en = 1'b1; #1;
    chk("bl_follow_1", {31'd0, d1_bl}, 32'd1);
    bl_en = 1'b0; #1;
    chk("bl_follow_0", {31'd0, d1_bl}, 32'd0);
    bl_en = 1'b1;

    @(negedge clk); resetn = 1'b1;
    n = 0;
    while (d1_rstn !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("lcd_reset_len", n, 4);

    k = 0; cyc = 0; under_done = 1'b0;
    while (q.size() < exp_q.size() && cyc < 20000) begin
      @(negedge clk); cyc++;
      if (k == 12 && !under_done && d1_ready) begin
        pix_valid = 1'b0; bad = 0;
        repeat (50) begin
          @(negedge clk); cyc++;
          if (d1_ready !== 1'b1 || d1_cs !== 1'b1) bad++;
        end
        under_done = 1'b1;
        chk("underrun_idle", bad, 0);
      end
      if (k < 16) begin
        pix_data = pix_tab[k]; pix_valid = 1'b1;
        if (d1_ready) k++;
      end else pix_valid = 1'b0;
    end
    chk("byte_count", q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < q.size()) chk($sformatf("byte_%0d", i), {22'd0, q[i]}, {22'd0, exp_q[i]});
    end
    chk("pixels_accepted", k, 16);
    chk("frame_start_pulses", fs_cnt, 3);
    chk("frame_start_width", fs_wide, 0);
    chk("d3_measured", {31'd0, d3_finished}, 32'd1);

    // reset while a pixel byte is on the wire
    pix_data = 16'hABCD; pix_valid = 1'b1;
    n = 0;
    while (d1_cs !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("midpix_busy", {31'd0, d1_cs}, 32'd0);
    #2 resetn = 1'b0; q.delete(); #1;
    chk("midpix_reset_outputs", {24'd0, d1_rstn, d1_cs, d1_rs, d1_clk, d1_data, d1_ready, d1_fs, d1_idone},
        {24'd0, 8'b0110_1000});
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    chk("restart_lcd_resetn", {31'd0, d1_rstn}, 32'd0);
    n = 0;
    while (q.size() < 1 && n < 2000) begin @(negedge clk); n++; end
    chk("restart_bytes", q.size(), 1);
    if (q.size() > 0) chk("restart_first_byte", {22'd0, q[0]}, {22'd0, 10'h011});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_lcd_stream_ctrl.md
SPI_LCD_STREAM_CTRL -- requirements
Module: spi_lcd_stream_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 240, visible columns.
REQ-002 SHALL have parameter V_RES, default 135, visible rows.
REQ-003 SHALL have parameter X_OFS, default 40, panel column offset.
REQ-004 SHALL have parameter Y_OFS, default 53, panel row offset.
REQ-005 SHALL have parameter MADCTL, default 8'h70, memory access control byte.
REQ-006 SHALL have parameter CLK_DIV, default 1 (min 1), half SPI bit period in clk cycles.
REQ-007 SHALL have parameters T_RESET, T_PREPARE and T_SNOOZE, defaults 2700000, 5400000 and 3240000, delay lengths in clk cycles.
REQ-008 Ports, clock and reset first:
  clk         in   1   system clock; reset resetn, asynchronous, active-low; clock clk.
  resetn      in   1   asynchronous active-low reset.
  pix_data    in   16  RGB565 pixel.
  pix_valid   in   1   pix_data valid.
  pix_ready   out  1   controller accepts pix_data this cycle.
  frame_start out  1   one-cycle pulse when a new frame window is opened.
  init_done   out  1   high once panel init has completed.
  bl_en       in   1   backlight enable.
  lcd_resetn  out  1   panel reset, active-low.
  lcd_clk     out  1   SPI clock.
  lcd_cs      out  1   SPI chip select, active-low.
  lcd_rs      out  1   0 = command, 1 = data.
  lcd_data    out  1   SPI MOSI.
  lcd_bl      out  1   backlight; equals bl_en combinationally.

Function
REQ-009 SHALL define one bit period as 2*CLK_DIV clk cycles: lcd_clk low for the first CLK_DIV cycles and high for the last CLK_DIV; lcd_data changes only when lcd_clk falls.
REQ-010 SHALL send each byte MSB first with lcd_cs low for 8 bit periods, lcd_rs stable for the whole byte, then lcd_cs high for 1 bit period.
REQ-011 SHALL hold lcd_clk low and lcd_data high whenever lcd_cs is high.
REQ-012 SHALL step through states RESET -> PREPARE -> WAKEUP -> SNOOZE -> INIT -> WINDOW -> STREAM.
REQ-013 SHALL hold lcd_resetn low in RESET for T_RESET cycles, then release it.
REQ-014 SHALL wait T_PREPARE cycles in PREPARE.
REQ-015 SHALL send command 0x11 in WAKEUP, then wait T_SNOOZE cycles in SNOOZE.
REQ-016 SHALL send the following sequence in INIT: cmd 0x36 with data MADCTL, cmd 0x3A with data 0x05, cmd 0x21, cmd 0x29.
REQ-017 SHALL set init_done high after the last INIT byte and keep it high until reset.
REQ-018 SHALL, on entering WINDOW, pulse frame_start for exactly 1 cycle.
REQ-019 SHALL then send, in WINDOW, cmd 0x2A with the 16-bit values X_OFS and X_OFS+H_RES-1, then cmd 0x2B with Y_OFS and Y_OFS+V_RES-1, then cmd 0x2C; all values big-endian, 16-bit truncated.
REQ-020 SHALL, in STREAM, assert pix_ready only while idle between pixels; a pixel is accepted on the cycle where pix_valid and pix_ready are both high.
REQ-021 SHALL deassert pix_ready the cycle after an acceptance, send pix_data[15:8] then pix_data[7:0] as data bytes, then reassert pix_ready.
REQ-022 SHALL, while pix_valid is low in STREAM (underrun), hold lcd_cs high indefinitely and send nothing, with no timeout.
REQ-023 SHALL count accepted pixels with a counter of $clog2(H_RES*V_RES+1) bits.
REQ-024 SHALL, after pixel H_RES*V_RES-1 has been fully sent, clear the counter and return to WINDOW for the next frame, wrapping with no pixel loss.
REQ-025 SHALL keep pix_ready low in every state other than STREAM.

Reset
REQ-026 SHALL, on resetn low, immediately and asynchronously drive lcd_resetn=0, lcd_cs=1, lcd_rs=1, lcd_clk=0, lcd_data=1, pix_ready=0, frame_start=0 and init_done=0, and clear all counters.
REQ-027 SHALL, if reset is asserted mid-byte or mid-frame, discard the partial transfer and restart from RESET when resetn deasserts.

Verification
REQ-028 SHALL cover boot with T_*=4, CLK_DIV=1: lcd_resetn rises after 4 cycles; the first byte is 0x11 with rs=0; init_done rises after 0x29.
REQ-029 SHALL cover a window with H_RES=4, V_RES=2, X_OFS=40, Y_OFS=53: bytes 2A 00 28 00 2B, then 2B 00 35 00 36, then 2C, with rs 0 on commands and 1 on data.
REQ-030 SHALL cover streaming with pix_valid held high and pixel 0xF800: bytes F8 then 00; frame_start pulses once per 8 pixels; 0x2A is resent after pixel 7.
REQ-031 SHALL cover underrun with pix_valid low for 50 cycles in mid-frame: lcd_cs stays high and pix_ready stays high; streaming resumes with the next pixel and none is dropped.
REQ-032 SHALL cover CLK_DIV=3: each lcd_clk phase lasts 3 cycles and a byte spans 48 cycles with cs low.
REQ-033 SHALL cover reset mid-pixel: all outputs take their reset values the same cycle, and after release the sequence restarts with lcd_resetn low.
